// File: rtl/shift_pipe.sv
// Five-stage pipelined 32-bit barrel shifter (SLL/SRA) with valid/ready flow control, global stall and flush.
// Optional macro SHIFT_PIPE_LSR_EN adds logical right shift (SRL) on ctrl_op = 2'b10.
module shift_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      data_operandA,
    input  logic [4:0]       ctrl_shiftamt,
    input  logic [1:0]       ctrl_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      data_result,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRA = 2'b01,
        SH_SRL = 2'b10
    } shift_kind_e;

    // One binary-weighted shift step; SRA keeps bit 31, which is the operand's sign at every stage.
    function automatic logic [31:0] shift_step(input logic [31:0] d, input shift_kind_e kind,
                                               input logic en, input int amt);
        logic [31:0] r;
        r = d;
        if (en) begin
            case (kind)
                SH_SRA:  r = $unsigned($signed(d) >>> amt);
`ifdef SHIFT_PIPE_LSR_EN
                SH_SRL:  r = d >> amt;
`endif
                default: r = d << amt;
            endcase
        end
        return r;
    endfunction

    shift_kind_e      kind_in;
    logic             advance;

    logic             valid_q [1:5];
    logic             valid_d [1:5];
    logic [31:0]      data_q  [1:5];
    logic [31:0]      data_d  [1:5];
    logic [TAG_W-1:0] tag_q   [1:5];
    logic [TAG_W-1:0] tag_d   [1:5];
    // Remaining shift-amount bits, left-aligned so the next stage always consumes bit 3.
    logic [3:0]       shamt_q [1:4];
    logic [3:0]       shamt_d [1:4];
    shift_kind_e      kind_q  [1:4];
    shift_kind_e      kind_d  [1:4];

    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        kind_in = SH_SRA;
`ifdef SHIFT_PIPE_LSR_EN
        case (ctrl_op)
            2'b00:   kind_in = SH_SLL;
            2'b10:   kind_in = SH_SRL;
            default: kind_in = SH_SRA;
        endcase
`else
        case (ctrl_op)
            2'b00, 2'b10: kind_in = SH_SLL;
            default:      kind_in = SH_SRA;
        endcase
`endif
    end

    always_comb begin
        advance = ~(valid_q[5] & ~out_ready);

        valid_d[1] = in_valid;
        data_d[1]  = shift_step(data_operandA, kind_in, ctrl_shiftamt[4], 16);
        tag_d[1]   = in_tag;
        shamt_d[1] = ctrl_shiftamt[3:0];
        kind_d[1]  = kind_in;

        for (int k = 2; k <= 5; k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = shift_step(data_q[k-1], kind_q[k-1], shamt_q[k-1][3], 1 << (5 - k));
            tag_d[k]   = tag_q[k-1];
        end
        for (int k = 2; k <= 4; k++) begin
            shamt_d[k] = shamt_q[k-1] << 1;
            kind_d[k]  = kind_q[k-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: these are pipeline registers, not a memory array, so every one is reset.
            for (int k = 1; k <= 5; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                tag_q[k]   <= '0;
            end
            for (int k = 1; k <= 4; k++) begin
                shamt_q[k] <= '0;
                kind_q[k]  <= SH_SLL;
            end
        end else begin
            if (advance) begin
                for (int k = 1; k <= 5; k++) begin
                    data_q[k] <= data_d[k];
                    tag_q[k]  <= tag_d[k];
                end
                for (int k = 1; k <= 4; k++) begin
                    shamt_q[k] <= shamt_d[k];
                    kind_q[k]  <= kind_d[k];
                end
            end
            // Flush wins over both advance and stall; only the valid bits matter.
            for (int k = 1; k <= 5; k++) begin
                if (flush)        valid_q[k] <= 1'b0;
                else if (advance) valid_q[k] <= valid_d[k];
            end
        end
    end

    assign in_ready    = advance;
    assign out_valid   = valid_q[5];
    assign data_result = data_q[5];
    assign out_tag     = tag_q[5];

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases plus randomized stream against a queue-based reference model.
module tb_shift_pipe;

    localparam int TAG_W = 5;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      data_operandA;
    logic [4:0]       ctrl_shiftamt;
    logic [1:0]       ctrl_op;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      data_result;
    logic [TAG_W-1:0] out_tag;

    shift_pipe #(.TAG_W(TAG_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .ctrl_shiftamt (ctrl_shiftamt),
        .ctrl_op       (ctrl_op),
        .in_tag        (in_tag),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .out_tag       (out_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: shift on a 64-bit sign/zero-extended value.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] amt,
                                              input logic [1:0] op);
        logic [63:0] ext;
        logic [63:0] sh;
        bit right;
        bit arith;
`ifdef SHIFT_PIPE_LSR_EN
        right = (op != 2'b00);
        arith = op[0];
`else
        right = op[0];
        arith = op[0];
`endif
        if (!right) return a << amt;
        ext = arith ? {{32{a[31]}}, a} : {32'b0, a};
        sh  = ext >> amt;
        return sh[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle with scoreboard bookkeeping; inputs are set by the caller beforehand.
    task automatic step_cycle(output bit acc);
        bit   hs;
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("stream_data", data_result, e.data);
                check("stream_tag", 32'(out_tag), 32'(e.tag));
            end
        end
        if (acc) begin
            e.data = ref_shift(data_operandA, ctrl_shiftamt, ctrl_op);
            e.tag  = in_tag;
            exp_q.push_back(e);
        end
        if (flush) exp_q.delete();
        @(posedge clock);
        #1;
    endtask

    // Single operation into an empty pipe, checking exact latency.
    task automatic run_single(input string name, input logic [31:0] a, input logic [4:0] amt,
                              input logic [1:0] op, input logic [TAG_W-1:0] tag,
                              input logic [31:0] expv);
        in_valid      = 1'b1;
        data_operandA = a;
        ctrl_shiftamt = amt;
        ctrl_op       = op;
        in_tag        = tag;
        out_ready     = 1'b1;
        #1;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({name, "_early_valid"}, 32'(out_valid), 32'd0);
            @(posedge clock);
            #1;
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, data_result, expv);
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
        @(posedge clock);
        #1;
        check({name, "_done"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          n;
        int          cnt;
        logic [31:0] hold_d;
        logic [TAG_W-1:0] hold_t;

        reset         = 1'b0;
        in_valid      = 1'b0;
        data_operandA = '0;
        ctrl_shiftamt = '0;
        ctrl_op       = '0;
        in_tag        = '0;
        flush         = 1'b0;
        out_ready     = 1'b1;
        #3;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", data_result, 32'd0);
        check("reset_tag", 32'(out_tag), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Directed single operations.
        run_single("sra16", 32'h8000_0000, 5'd16, 2'b01, 5'd3, 32'hFFFF_8000);
        run_single("sll31", 32'h0000_0001, 5'd31, 2'b00, 5'd4, 32'h8000_0000);
        run_single("sra31_pos", 32'h7FFF_FFFF, 5'd31, 2'b01, 5'd5, 32'h0000_0000);
        run_single("sra31_neg", 32'h8000_0000, 5'd31, 2'b01, 5'd6, 32'hFFFF_FFFF);
        run_single("shamt0", 32'hDEAD_BEEF, 5'd0, 2'b01, 5'd7, 32'hDEAD_BEEF);
`ifdef SHIFT_PIPE_LSR_EN
        run_single("op10", 32'h8000_0000, 5'd16, 2'b10, 5'd8, 32'h0000_8000);
`else
        run_single("op10", 32'h8000_0000, 5'd16, 2'b10, 5'd8, 32'h0000_0000);
`endif
        run_single("op11", 32'h8000_0000, 5'd4, 2'b11, 5'd9, 32'hF800_0000);

        // Back-to-back: SLL 1 by 0..9.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid      = 1'b1;
            data_operandA = 32'h1;
            ctrl_shiftamt = 5'(i);
            ctrl_op       = 2'b00;
            in_tag        = TAG_W'(i);
            step_cycle(acc);
            check("b2b_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 20) begin
            check("b2b_contig", 32'(out_valid), 32'd1);
            step_cycle(acc);
            cnt++;
        end
        check("b2b_drain_cycles", 32'(cnt), 32'd5);

        // Backpressure: out_ready low for three cycles mid-stream.
        n = 0;
        hold_d = '0;
        hold_t = '0;
        for (int c = 0; c < 40 && (n < 8 || exp_q.size() > 0); c++) begin
            in_valid      = (n < 8);
            data_operandA = 32'hC000_0000 | 32'(n * 32'h0101);
            ctrl_shiftamt = 5'(n + 1);
            ctrl_op       = 2'b01;
            in_tag        = TAG_W'(n + 16);
            out_ready     = !(c >= 5 && c <= 7);
            if (c == 5) begin
                check("bp_valid_at_stall", 32'(out_valid), 32'd1);
                hold_d = data_result;
                hold_t = out_tag;
            end
            step_cycle(acc);
            if (acc) n++;
            if (c >= 5 && c <= 7) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_data", data_result, hold_d);
                check("bp_hold_tag", 32'(out_tag), 32'(hold_t));
                check("bp_in_ready", 32'(in_ready), 32'd0);
            end
        end
        check("bp_all_accepted", 32'(n), 32'd8);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Flush: three ops in flight plus one presented on the flush edge.
        for (int i = 0; i < 3; i++) begin
            in_valid      = 1'b1;
            data_operandA = 32'h1234_5678;
            ctrl_shiftamt = 5'(i);
            ctrl_op       = 2'b00;
            in_tag        = TAG_W'(i + 20);
            step_cycle(acc);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        step_cycle(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("flush_no_valid", 32'(out_valid), 32'd0);
            step_cycle(acc);
        end
        run_single("post_flush", 32'hF000_0000, 5'd4, 2'b01, 5'd11, 32'hFF00_0000);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) begin
            in_valid      = 1'b1;
            data_operandA = 32'h5;
            ctrl_shiftamt = 5'd1;
            ctrl_op       = 2'b00;
            in_tag        = TAG_W'(i + 1);
            step_cycle(acc);
        end
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        check("rst_pre_data", data_result, 32'hA);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_data", data_result, 32'd0);
        check("rst_async_tag", 32'(out_tag), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        run_single("post_reset", 32'h3, 5'd1, 2'b00, 5'd12, 32'h6);

        // Randomized stream with random backpressure.
        for (int c = 0; c < 300; c++) begin
            in_valid      = ($urandom_range(0, 9) < 7);
            data_operandA = $urandom;
            ctrl_shiftamt = 5'($urandom);
            ctrl_op       = 2'($urandom);
            in_tag        = TAG_W'($urandom);
            out_ready     = ($urandom_range(0, 9) < 7);
            step_cycle(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 20) begin
            step_cycle(acc);
            cnt++;
        end
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rand_out_idle", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
